// File: rtl/bus_responder_if.sv
// CPU external bus between the CPU (master) and the bus responder (slave).
// read/write are one-cycle strobes; ready is a one-cycle completion pulse.
interface bus_responder_if;
    logic       read;
    logic       write;
    logic [7:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       ready;

    modport master (
        output read,
        output write,
        output address,
        output data_in,
        input  data_out,
        input  ready
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  data_in,
        output data_out,
        output ready
    );
endinterface

// File: rtl/bus_responder.sv
// Bus target for the CPU external bus. RAM below IO_BASE, a small register
// block above it, and a programmable number of wait cycles before the
// one-cycle ready pulse so the CPU stall logic gets exercised.
module bus_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  IO_BASE     = 8'hF0
) (
    input  logic            clk,
    input  logic            reset,
    bus_responder_if.slave  bus,
    input  logic [7:0]      port_in,
    output logic [7:0]      port_out,
    output logic            err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    localparam logic [7:0] AddrPortIn  = IO_BASE;
    localparam logic [7:0] AddrPortOut = IO_BASE + 8'd1;
    localparam logic [7:0] AddrTick    = IO_BASE + 8'd2;
    localparam logic [7:0] AddrScratch = IO_BASE + 8'd3;

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);
    localparam bit         NoWait   = (WAIT_CYCLES == 0);
    localparam int         RamDepth = int'(IO_BASE);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       wr_q;
    logic [7:0] data_out_q;
    logic [7:0] port_out_q;
    logic [7:0] scratch_q;
    logic [7:0] tick_q;
    logic       err_q;

    logic [7:0] ram [0:RamDepth-1];

    logic       idle;
    logic       strobe;
    logic       accept;
    logic       collision;
    logic       stray;
    logic       enter_ack;
    logic [7:0] live_rdata;
    logic [7:0] c_addr;
    logic [7:0] c_wdata;
    logic [7:0] c_rdata;
    logic       c_write;
    logic       ram_we;

    assign idle      = (state_q == StIdle);
    assign strobe    = bus.read | bus.write;
    assign accept    = idle & strobe;
    // Read wins a read/write collision; the write half is discarded.
    assign collision = idle & bus.read & bus.write;
    assign stray     = ~idle & strobe;

    // Read value as seen at the accepting edge: RAM or the I/O register file.
    always_comb begin
        live_rdata = 8'h00;
        if (bus.address < IO_BASE) begin
            live_rdata = ram[bus.address];
        end else begin
            case (bus.address)
                AddrPortIn:  live_rdata = port_in;
                AddrPortOut: live_rdata = port_out_q;
                AddrTick:    live_rdata = tick_q;
                AddrScratch: live_rdata = scratch_q;
                default:     live_rdata = 8'h00;
            endcase
        end
    end

    // Request FSM: IDLE -> WAIT (counting) -> ACK -> IDLE, WAIT skipped if no wait cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_ack = 1'b0;
        case (state_q)
            StIdle: begin
                if (strobe) begin
                    if (NoWait) begin
                        state_d   = StAck;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = StAck;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With no wait cycles the ACK entry coincides with the accept edge, so take
    // the live bus values there instead of the latched copies.
    always_comb begin
        c_addr  = idle ? bus.address : addr_q;
        c_wdata = idle ? bus.data_in : wdata_q;
        c_write = idle ? (bus.write & ~bus.read) : wr_q;
        c_rdata = idle ? live_rdata : rdata_q;
        ram_we  = enter_ack & c_write & (c_addr < IO_BASE);
    end

    // Request capture, read-data return, register commits and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            data_out_q <= 8'h00;
            port_out_q <= 8'h00;
            scratch_q  <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.address;
                wdata_q <= bus.data_in;
                wr_q    <= bus.write & ~bus.read;
                rdata_q <= live_rdata;
            end
            if (enter_ack) begin
                if (!c_write) begin
                    data_out_q <= c_rdata;
                end else if (c_addr == AddrPortOut) begin
                    port_out_q <= c_wdata;
                end else if (c_addr == AddrScratch) begin
                    scratch_q <= c_wdata;
                end
            end
            if (collision || stray) begin
                err_q <= 1'b1;
            end
        end
    end

    // Free-running tick counter, readable at the tick address.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 8'h00;
        end else begin
            tick_q <= tick_q + 8'd1;
        end
    end

    // RAM write port; contents survive reset, but an aborted request never commits.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            ram[c_addr] <= c_wdata;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = (state_q == StAck);
    assign port_out     = port_out_q;
    assign err          = err_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder with two wait cycles.
module tb_bus_responder;

    logic       clk;
    logic       reset;
    logic [7:0] port_in;
    logic [7:0] port_out;
    logic       err;
    int         checks;
    int         errors;
    int         cyc;

    bus_responder_if bus ();

    bus_responder #(
        .WAIT_CYCLES (2),
        .IO_BASE     (8'hF0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .port_in  (port_in),
        .port_out (port_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release; equals the tick value before each edge.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // One request; samples ready at each falling edge after the accepting edge.
    // extra_k / rst_k inject a stray write or a one-cycle reset after sample k.
    task automatic transact(input logic rd, input logic wr, input logic [7:0] addr,
                            input logic [7:0] din, input int extra_k, input int rst_k,
                            output int rdy_at, output int rdy_cnt,
                            output logic [7:0] dout, output logic [7:0] tick_exp);
        @(negedge clk);
        bus.read    = rd;
        bus.write   = wr;
        bus.address = addr;
        bus.data_in = din;
        tick_exp    = 8'(cyc);
        rdy_at      = -1;
        rdy_cnt     = 0;
        dout        = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.read  = 1'b0;
            bus.write = 1'b0;
            if (k == rst_k + 1) reset = 1'b0;
            if (bus.ready) begin
                rdy_cnt++;
                if (rdy_at < 0) begin
                    rdy_at = k;
                    dout   = bus.data_out;
                end
            end
            if (k == extra_k) begin
                bus.write   = 1'b1;
                bus.address = addr + 8'd1;
                bus.data_in = ~din;
            end
            if (k == rst_k) reset = 1'b1;
        end
    endtask

    initial begin
        int         at;
        int         cnt;
        logic [7:0] d;
        logic [7:0] tk;

        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        port_in     = 8'h00;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.address = 8'h00;
        bus.data_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check8("rst_ready", 8'(bus.ready), 8'h00);
        check8("rst_data_out", bus.data_out, 8'h00);
        check8("rst_port_out", port_out, 8'h00);
        check8("rst_err", 8'(err), 8'h00);
        reset = 1'b0;

        // One edge passes after release, so tick is 0x01 at the accepting edge.
        transact(1'b1, 1'b0, 8'hF2, 8'h00, -1, -1, at, cnt, d, tk);
        check8("tick_after_release", d, 8'h01);

        // Write then read back with two wait cycles: ready two edges after accept.
        transact(1'b0, 1'b1, 8'h10, 8'hA5, -1, -1, at, cnt, d, tk);
        check8("wr10_ready_at", 8'(at), 8'd2);
        check8("wr10_ready_cnt", 8'(cnt), 8'd1);
        transact(1'b1, 1'b0, 8'h10, 8'h00, -1, -1, at, cnt, d, tk);
        check8("rd10_ready_at", 8'(at), 8'd2);
        check8("rd10_data", d, 8'hA5);

        // RAM top and the read-only input port.
        port_in = 8'h33;
        transact(1'b0, 1'b1, 8'hEF, 8'h5A, -1, -1, at, cnt, d, tk);
        transact(1'b0, 1'b1, 8'hF0, 8'h77, -1, -1, at, cnt, d, tk);
        check8("wrF0_acked", 8'(cnt), 8'd1);
        transact(1'b1, 1'b0, 8'hEF, 8'h00, -1, -1, at, cnt, d, tk);
        check8("rdEF_data", d, 8'h5A);
        transact(1'b1, 1'b0, 8'hF0, 8'h00, -1, -1, at, cnt, d, tk);
        check8("rdF0_port_in", d, 8'h33);
        check8("boundary_err", 8'(err), 8'h00);

        // Output port register; data_out keeps the last read value across a write.
        transact(1'b0, 1'b1, 8'hF1, 8'h3C, -1, -1, at, cnt, d, tk);
        check8("port_out_written", port_out, 8'h3C);
        check8("data_out_held", bus.data_out, 8'h33);
        transact(1'b1, 1'b0, 8'hF1, 8'h00, -1, -1, at, cnt, d, tk);
        check8("rdF1_data", d, 8'h3C);

        // Scratch register and the reserved window.
        transact(1'b0, 1'b1, 8'hF3, 8'hC7, -1, -1, at, cnt, d, tk);
        transact(1'b1, 1'b0, 8'hF3, 8'h00, -1, -1, at, cnt, d, tk);
        check8("rdF3_scratch", d, 8'hC7);
        transact(1'b0, 1'b1, 8'hF8, 8'h55, -1, -1, at, cnt, d, tk);
        check8("wrF8_acked", 8'(cnt), 8'd1);
        transact(1'b1, 1'b0, 8'hF8, 8'h00, -1, -1, at, cnt, d, tk);
        check8("rdF8_zero", d, 8'h00);
        check8("reserved_err", 8'(err), 8'h00);

        // Tick sampled at the accepting edge.
        transact(1'b1, 1'b0, 8'hF2, 8'h00, -1, -1, at, cnt, d, tk);
        check8("tick_running", d, tk);

        // Read and write together: read wins, write dropped, error latched.
        transact(1'b0, 1'b1, 8'h20, 8'h11, -1, -1, at, cnt, d, tk);
        transact(1'b1, 1'b1, 8'h20, 8'h99, -1, -1, at, cnt, d, tk);
        check8("collide_data", d, 8'h11);
        check8("collide_ready_cnt", 8'(cnt), 8'd1);
        check8("collide_err", 8'(err), 8'h01);
        transact(1'b1, 1'b0, 8'h20, 8'h00, -1, -1, at, cnt, d, tk);
        check8("collide_ram_kept", d, 8'h11);

        // Reset clears registers and the error flag but not RAM.
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check8("rst2_err", 8'(err), 8'h00);
        check8("rst2_port_out", port_out, 8'h00);
        check8("rst2_data_out", bus.data_out, 8'h00);
        reset = 1'b0;
        transact(1'b1, 1'b0, 8'hF3, 8'h00, -1, -1, at, cnt, d, tk);
        check8("rst2_scratch", d, 8'h00);
        transact(1'b1, 1'b0, 8'h10, 8'h00, -1, -1, at, cnt, d, tk);
        check8("rst2_ram_kept", d, 8'hA5);

        // Stray write during WAIT: single ready, in-flight write intact, stray dropped.
        transact(1'b0, 1'b1, 8'h31, 8'h12, -1, -1, at, cnt, d, tk);
        check8("pre_stray_err", 8'(err), 8'h00);
        transact(1'b0, 1'b1, 8'h30, 8'h66, 0, -1, at, cnt, d, tk);
        check8("stray_ready_cnt", 8'(cnt), 8'd1);
        check8("stray_ready_at", 8'(at), 8'd2);
        check8("stray_err", 8'(err), 8'h01);
        transact(1'b1, 1'b0, 8'h30, 8'h00, -1, -1, at, cnt, d, tk);
        check8("stray_inflight", d, 8'h66);
        transact(1'b1, 1'b0, 8'h31, 8'h00, -1, -1, at, cnt, d, tk);
        check8("stray_dropped", d, 8'h12);

        // Reset during WAIT: no ready, no commit.
        transact(1'b0, 1'b1, 8'h40, 8'h21, -1, -1, at, cnt, d, tk);
        transact(1'b0, 1'b1, 8'h40, 8'hEE, -1, 0, at, cnt, d, tk);
        check8("abort_ready_cnt", 8'(cnt), 8'd0);
        check8("abort_err", 8'(err), 8'h00);
        transact(1'b1, 1'b0, 8'h40, 8'h00, -1, -1, at, cnt, d, tk);
        check8("abort_ram_kept", d, 8'h21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
